// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer.
package word_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // ceil(log2(n)), never less than 1 so a single-slice bus still has an index bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/word_serializer_word_pick.sv
// Combinational lowest-set-bit picker over the pending slice mask.
module word_pick
   import word_serializer_pkg::*;
#(
   parameter int WORD_NUM = 4,
   parameter int IDX_W    = 2
) (
   input  logic [WORD_NUM-1:0] mask_i,
   output logic [IDX_W-1:0]    idx_o,
   output logic                any_o,
   output logic                onehot_o
);

   // Scan from the top down so the final assignment is the lowest set bit.
   always_comb begin
      idx_o = '0;
      for (int i = WORD_NUM - 1; i >= 0; i--) begin
         if (mask_i[i]) idx_o = IDX_W'(i);
      end
   end

   // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
   always_comb begin
      any_o    = (mask_i != '0);
      onehot_o = any_o && ((mask_i & (mask_i - WORD_NUM'(1))) == '0);
   end

endmodule

// File: rtl/word_serializer.sv
// Bus-word to narrow-word serializer: emits flagged slices lowest index first.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int  BUS_SIZE  = 16,
   parameter int  WORD_SIZE = 4,
   localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE,
   localparam int IDX_W     = clog2_min1(WORD_NUM)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_SIZE-1:0]  data_in,
   input  logic [WORD_NUM-1:0]  control,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_SIZE-1:0] word_out,
   output logic [IDX_W-1:0]     word_idx,
   output logic                 word_valid,
   output logic                 word_last,
   input  logic                 out_ready
);

   state_e              state_q, state_d;
   logic [BUS_SIZE-1:0] data_q, data_d;
   logic [WORD_NUM-1:0] mask_q, mask_d;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 pick_onehot;
   logic [WORD_SIZE-1:0] slice;

   word_pick #(
      .WORD_NUM (WORD_NUM),
      .IDX_W    (IDX_W)
   ) u_pick (
      .mask_i   (mask_q),
      .idx_o    (pick_idx),
      .any_o    (pick_any),
      .onehot_o (pick_onehot)
   );

   // Select the slice of the held bus word addressed by the picked index.
   always_comb begin
      slice = '0;
      for (int i = 0; i < WORD_NUM; i++) begin
         if (pick_idx == IDX_W'(i)) slice = data_q[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   // State, held bus word and pending mask; reset drops word_valid immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state and handshake outputs; slice outputs are forced to zero outside SEND.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      mask_d     = mask_q;
      in_ready   = 1'b0;
      word_valid = 1'b0;
      word_last  = 1'b0;
      word_out   = '0;
      word_idx   = '0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d = data_in;
               mask_d = control;
               if (control != '0) state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            word_valid = pick_any;
            word_last  = pick_onehot;
            word_out   = slice;
            word_idx   = pick_idx;
            if (!pick_any) begin
               state_d = ST_IDLE;
            end else if (out_ready) begin
               // Clearing the lowest set bit retires exactly the slice just sent.
               mask_d = mask_q & (mask_q - WORD_NUM'(1));
               if (pick_onehot) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic [3:0]  control;
   logic        in_valid, out_ready;
   logic        in_ready, word_valid, word_last;
   logic [3:0]  word_out;
   logic [1:0]  word_idx;

   logic [7:0]  data_in8;
   logic [1:0]  control8;
   logic        in_valid8, out_ready8;
   logic        in_ready8, word_valid8, word_last8;
   logic [3:0]  word_out8;
   logic [0:0]  word_idx8;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   word_serializer dut (
      .clk(clk), .reset(reset), .data_in(data_in), .control(control),
      .in_valid(in_valid), .in_ready(in_ready), .word_out(word_out),
      .word_idx(word_idx), .word_valid(word_valid), .word_last(word_last),
      .out_ready(out_ready)
   );

   word_serializer #(.BUS_SIZE(8), .WORD_SIZE(4)) dut8 (
      .clk(clk), .reset(reset), .data_in(data_in8), .control(control8),
      .in_valid(in_valid8), .in_ready(in_ready8), .word_out(word_out8),
      .word_idx(word_idx8), .word_valid(word_valid8), .word_last(word_last8),
      .out_ready(out_ready8)
   );

   typedef struct {
      logic        iv;
      logic [15:0] d;
      logic [3:0]  c;
      logic        ordy;
      logic        e_ir;
      logic        e_v;
      logic [3:0]  e_w;
      logic [1:0]  e_idx;
      logic        e_last;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else pass_cnt++;
   endtask

   function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic [3:0] c,
                               input logic ordy, input logic e_ir, input logic e_v,
                               input logic [3:0] e_w, input logic [1:0] e_idx,
                               input logic e_last);
      vec_t v;
      v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
      v.e_ir = e_ir; v.e_v = e_v; v.e_w = e_w; v.e_idx = e_idx; v.e_last = e_last;
      return v;
   endfunction

   task automatic chk_out(input string tag, input logic ir, input logic v,
                          input logic [3:0] w, input logic [1:0] idx, input logic last);
      chk({tag, ".in_ready"},   32'(in_ready),   32'(ir));
      chk({tag, ".word_valid"}, 32'(word_valid), 32'(v));
      chk({tag, ".word_out"},   32'(word_out),   32'(w));
      chk({tag, ".word_idx"},   32'(word_idx),   32'(idx));
      chk({tag, ".word_last"},  32'(word_last),  32'(last));
   endtask

   initial begin
      reset = 1'b1;
      data_in = '0; control = '0; in_valid = 1'b0; out_ready = 1'b1;
      data_in8 = '0; control8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;

      // Each entry: outputs expected this cycle, inputs driven for the coming edge.
      //            iv  data      ctl    ordy  ir v  w     idx last
      vt.push_back(mk(1, 16'hA5C3, 4'hF, 1,   1, 0, 4'h0, 0, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   0, 1, 4'h3, 0, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   0, 1, 4'hC, 1, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   0, 1, 4'h5, 2, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   0, 1, 4'hA, 3, 1));
      vt.push_back(mk(1, 16'h1234, 4'hA, 1,   1, 0, 4'h0, 0, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   0, 1, 4'h3, 1, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   0, 1, 4'h1, 3, 1));
      vt.push_back(mk(1, 16'h5555, 4'h0, 1,   1, 0, 4'h0, 0, 0));
      vt.push_back(mk(1, 16'hA5C3, 4'hF, 0,   1, 0, 4'h0, 0, 0));
      vt.push_back(mk(1, 16'hFFFF, 4'hF, 0,   0, 1, 4'h3, 0, 0));
      vt.push_back(mk(1, 16'hFFFF, 4'hF, 0,   0, 1, 4'h3, 0, 0));
      vt.push_back(mk(1, 16'hFFFF, 4'hF, 1,   0, 1, 4'h3, 0, 0));
      vt.push_back(mk(1, 16'hFFFF, 4'hF, 1,   0, 1, 4'hC, 1, 0));
      vt.push_back(mk(1, 16'hFFFF, 4'hF, 1,   0, 1, 4'h5, 2, 0));
      vt.push_back(mk(1, 16'hFFFF, 4'hF, 1,   0, 1, 4'hA, 3, 1));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   1, 0, 4'h0, 0, 0));
      vt.push_back(mk(0, 16'h0000, 4'h0, 1,   1, 0, 4'h0, 0, 0));

      #1;
      chk_out("reset", 1, 0, 4'h0, 2'd0, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vt[n]) begin
         @(negedge clk);
         chk_out($sformatf("vec%0d", n), vt[n].e_ir, vt[n].e_v, vt[n].e_w, vt[n].e_idx,
                 vt[n].e_last);
         in_valid  = vt[n].iv;
         data_in   = vt[n].d;
         control   = vt[n].c;
         out_ready = vt[n].ordy;
      end

      // Reset in the middle of a four-slice word, after two transfers.
      @(negedge clk);
      in_valid = 1'b1; data_in = 16'hA5C3; control = 4'hF; out_ready = 1'b1;
      @(negedge clk);
      chk_out("mid.w0", 0, 1, 4'h3, 2'd0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk_out("mid.w1", 0, 1, 4'hC, 2'd1, 0);
      @(negedge clk);
      chk_out("mid.w2", 0, 1, 4'h5, 2'd2, 0);
      reset = 1'b1;
      #1;
      chk_out("mid.rst", 1, 0, 4'h0, 2'd0, 0);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1; data_in = 16'h000F; control = 4'b0001;
      @(negedge clk);
      chk_out("post.w", 0, 1, 4'hF, 2'd0, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk_out("post.idle", 1, 0, 4'h0, 2'd0, 0);

      // Narrow 8-bit bus with two slices.
      in_valid8 = 1'b1; data_in8 = 8'h9E; control8 = 2'b11; out_ready8 = 1'b1;
      @(negedge clk);
      chk("b8.w0.valid", 32'(word_valid8), 32'd1);
      chk("b8.w0.word",  32'(word_out8),   32'hE);
      chk("b8.w0.idx",   32'(word_idx8),   32'd0);
      chk("b8.w0.last",  32'(word_last8),  32'd0);
      in_valid8 = 1'b0;
      @(negedge clk);
      chk("b8.w1.valid", 32'(word_valid8), 32'd1);
      chk("b8.w1.word",  32'(word_out8),   32'h9);
      chk("b8.w1.idx",   32'(word_idx8),   32'd1);
      chk("b8.w1.last",  32'(word_last8),  32'd1);
      @(negedge clk);
      chk("b8.idle.valid", 32'(word_valid8), 32'd0);
      chk("b8.idle.ready", 32'(in_ready8),   32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
